// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a bit-serial adder: one granted requester at a time
// has its operands added LSB first over SIZE cycles, then gets a one-cycle done pulse.
module serial_add_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_bus,
  input  logic [NREQ*SIZE-1:0] b_bus,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [NREQ-1:0]      done,
  output logic [SIZE:0]        sum,
  output logic [1:0]           sum_id
);

  // state    | meaning
  // ST_IDLE  | waiting; arbitrates req on each edge
  // ST_SHIFT | adding one bit pair per cycle for the owner
  // ST_DONE  | one-cycle completion pulse, pointer advances
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_t            state, state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        owner;
  logic [1:0]        pick;
  logic              found;
  logic              grant_en;
  logic [SIZE-1:0]   a_sel, b_sel;
  logic [SIZE-1:0]   a_sh, b_sh;
  logic [SIZE-2:0]   res_sh;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              bit_sum, bit_carry;
  logic [NREQ-1:0]   gnt_nxt, done_nxt;
  logic              busy_nxt;
  logic [1:0]        cand;

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == 2'(k)) begin
        a_sel = a_bus[k*SIZE +: SIZE];
        b_sel = b_bus[k*SIZE +: SIZE];
      end
    end
  end

  assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    gnt_nxt   = '0;
    done_nxt  = '0;
    case (state)
      ST_IDLE: begin
        if (req != '0) begin
          state_nxt = ST_SHIFT;
          grant_en  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state_nxt == ST_SHIFT) gnt_nxt = NREQ'(1) << (grant_en ? pick : owner);
    if (state_nxt == ST_DONE)  done_nxt = NREQ'(1) << owner;
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      sum    <= '0;
      sum_id <= '0;
      ptr    <= '0;
      owner  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      if (grant_en) begin
        owner  <= pick;
        a_sh   <= a_sel;
        b_sh   <= b_sel;
        res_sh <= '0;
        carry  <= 1'b0;
        cnt    <= '0;
      end else if (state == ST_SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= bit_carry;
        cnt    <= cnt + CW'(1);
        res_sh <= (SIZE > 2) ? {bit_sum, res_sh[SIZE-2:1]} : bit_sum;
        // last bit: low SIZE-1 bits already sit in res_sh, append this bit and carry-out
        if (cnt == LAST) begin
          sum    <= {bit_carry, bit_sum, res_sh};
          sum_id <= owner;
        end
      end
      if (state == ST_DONE) ptr <= owner + 2'd1;
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench: transaction-level reference model checked every cycle,
// a vector table of single operations, and hand-written multi-cycle sequences.
module tb_serial_add_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] a_bus, b_bus;
  logic [NREQ-1:0]      gnt, done;
  logic                 busy;
  logic [SIZE:0]        sum;
  logic [1:0]           sum_id;

  serial_add_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .done(done), .sum(sum), .sum_id(sum_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int v3, input int v2, input int v1, input int v0);
    return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  // reference model: phase 0 idle, 1..SIZE granted, SIZE+1 completion cycle
  int           m_phase = 0;
  int           m_owner = 0;
  int           m_ptr = 0;
  int           m_res = 0;
  int           m_sum = 0;
  int           m_id = 0;

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic int op_sum(input int w);
    return int'(a_bus[w*SIZE +: SIZE]) + int'(b_bus[w*SIZE +: SIZE]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_ptr <= 0; m_sum <= 0; m_id <= 0; m_owner <= 0;
    end else if (m_phase == 0) begin
      if (req != 4'b0) begin
        m_owner <= rr_pick(m_ptr, req);
        m_res   <= op_sum(rr_pick(m_ptr, req));
        m_phase <= 1;
      end
    end else if (m_phase == SIZE) begin
      m_sum   <= m_res;
      m_id    <= m_owner;
      m_ptr   <= (m_owner + 1) % 4;
      m_phase <= SIZE + 1;
    end else if (m_phase == SIZE + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst === 1'b1) begin
      check("model_gnt",  gnt,  (m_phase >= 1 && m_phase <= SIZE) ? (1 << m_owner) : 0);
      check("model_done", done, (m_phase == SIZE + 1) ? (1 << m_owner) : 0);
      check("model_busy", busy, (m_phase != 0) ? 1 : 0);
      check("model_sum",  sum,  m_sum);
      check("model_id",   sum_id, m_id);
    end
  end

  // waits for the next done pulse; returns owner, grant-to-done distance and first grant
  task automatic run_op(output int id, output int lat, output int first_gnt, output bit ok);
    int gfirst;
    gfirst = -1; ok = 1'b0; id = -1; lat = -1; first_gnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != 4'b0 && gfirst < 0) begin
        gfirst = c; first_gnt = int'(gnt);
      end
      if (done != 4'b0) begin
        ok = 1'b1;
        lat = (gfirst < 0) ? -1 : c - gfirst;
        for (int k = 0; k < 4; k++) if (done[k]) id = k;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic wait_gnt();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt != 4'b0) seen = 1'b1;
    end
    if (!seen) check("gnt_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    int          sum;
  } vec_t;

  vec_t tbl[8];
  int id, lat, fg;
  bit ok;
  time t_prev;
  int exp_ids[5]  = '{0, 1, 2, 3, 0};
  int exp_sums[5] = '{2, 4, 6, 8, 2};

  initial begin
    rst = 1'b0; req = 4'b0; a_bus = '0; b_bus = '0;
    // pointer walks 0 -> 1 -> 3 -> 3 -> 1 -> 2 -> 0 -> 0 through the table
    tbl[0] = '{4'b0001, pk(0, 0, 0, 143),   pk(0, 0, 0, 57),    0, 200};
    tbl[1] = '{4'b0100, pk(0, 255, 0, 0),   pk(0, 255, 0, 0),   2, 510};
    tbl[2] = '{4'b0100, pk(0, 0, 0, 0),     pk(0, 0, 0, 0),     2, 0};
    tbl[3] = '{4'b0011, pk(0, 0, 100, 1),   pk(0, 0, 50, 2),    0, 3};
    tbl[4] = '{4'b0011, pk(0, 0, 100, 1),   pk(0, 0, 50, 2),    1, 150};
    tbl[5] = '{4'b1001, pk(200, 0, 0, 5),   pk(100, 0, 0, 5),   3, 300};
    tbl[6] = '{4'b1000, pk(128, 0, 0, 0),   pk(128, 0, 0, 0),   3, 256};
    tbl[7] = '{4'b0110, pk(0, 40, 7, 0),    pk(0, 40, 9, 0),    1, 16};

    #12;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_id", sum_id, 0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; a_bus = tbl[i].a; b_bus = tbl[i].b;
      run_op(id, lat, fg, ok);
      check($sformatf("vec%0d_id", i), id, tbl[i].id);
      check($sformatf("vec%0d_gnt", i), fg, 1 << tbl[i].id);
      check($sformatf("vec%0d_sum", i), sum, tbl[i].sum);
      check($sformatf("vec%0d_sum_id", i), sum_id, tbl[i].id);
      check($sformatf("vec%0d_latency", i), lat, SIZE);
    end
    req = 4'b0;

    // fairness from a fresh pointer
    do_reset();
    req = 4'b1111; a_bus = pk(4, 3, 2, 1); b_bus = pk(4, 3, 2, 1);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(id, lat, fg, ok);
      check($sformatf("fair%0d_id", i), id, exp_ids[i]);
      check($sformatf("fair%0d_sum", i), sum, exp_sums[i]);
      if (i > 0) check($sformatf("fair%0d_spacing", i), longint'($time - t_prev), 10 * (SIZE + 2));
      t_prev = $time;
    end
    req = 4'b0;
    repeat (3) @(negedge clk);

    // hog: requester 0 held, requester 2 joins mid-operation
    req = 4'b0001; a_bus = pk(0, 11, 0, 5); b_bus = pk(0, 22, 0, 6);
    wait_gnt();
    repeat (2) @(negedge clk);
    req = 4'b0101;
    run_op(id, lat, fg, ok);
    check("hog_first", id, 0);
    run_op(id, lat, fg, ok);
    check("hog_second", id, 2);
    check("hog_second_sum", sum, 33);
    run_op(id, lat, fg, ok);
    check("hog_third", id, 0);
    req = 4'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of an addition
    req = 4'b0010; a_bus = pk(0, 0, 67, 0); b_bus = pk(0, 0, 33, 0);
    wait_gnt();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_id", sum_id, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst = 1'b1;
    run_op(id, lat, fg, ok);
    check("midrst_id_after", id, 1);
    check("midrst_sum_after", sum, 100);
    check("midrst_latency", lat, SIZE);
    req = 4'b0;
    repeat (2) @(negedge clk);

    // operands and request change after grant
    req = 4'b0001; a_bus = pk(0, 0, 0, 10); b_bus = pk(0, 0, 0, 20);
    wait_gnt();
    a_bus = pk(0, 0, 0, 99); b_bus = pk(0, 0, 0, 200); req = 4'b0;
    run_op(id, lat, fg, ok);
    check("opchg_id", id, 0);
    check("opchg_sum", sum, 30);
    repeat (2) @(negedge clk);

    // randomized traffic with one asynchronous reset pulse
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      a_bus = $urandom;
      b_bus = $urandom;
      if (c == 400) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rnd_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
      end
    end
    req = 4'b0;
    repeat (12) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
